// File: rtl/mips_fetch_unit.sv
// MIPS fetch stage: PC, one-outstanding imem req/rvalid fetch, skid buffer and IF/ID register.
// Latency: req -> IF/ID one edge after rvalid; 1-cycle memory gives one instruction per 2 cycles.
// Backpressure: stall holds IF/ID and parks a completing word in the skid buffer; redirect flushes.
// Optional perf counters (fetch_count, bubble_count) are built when MIPS_FETCH_PERF_EN is defined.
module mips_fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              instr_valid
`ifdef MIPS_FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       bubble_count
`endif
);

    typedef enum logic [1:0] {
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN
    } state_t;

    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         skid_q, skid_d;
    logic [31:0]         instr_q, instr_d;
    logic [ADDR_W-1:0]   pcp4_q, pcp4_d;
    logic                vld_q, vld_d;
    logic                load_mem, load_skid, flush, bubble;

    // Next-state decode. req_q is low only in the first ISSUE cycle after reset, when
    // no request is actually on the bus, so ISSUE must not advance until it has fired.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        skid_d    = skid_q;
        load_mem  = 1'b0;
        load_skid = 1'b0;
        flush     = 1'b0;
        if (redirect) begin
            flush = 1'b1;
            pc_d  = redirect_pc & ALIGN_MASK;
            unique case (state_q)
                ST_ISSUE: state_d = req_q ? ST_DRAIN : ST_ISSUE;
                ST_WAIT:  state_d = imem_rvalid ? ST_ISSUE : ST_DRAIN;
                ST_HOLD:  state_d = ST_ISSUE;
                ST_DRAIN: state_d = imem_rvalid ? ST_ISSUE : ST_DRAIN;
                default:  state_d = ST_ISSUE;
            endcase
        end else begin
            unique case (state_q)
                ST_ISSUE: begin
                    if (req_q) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        pc_d = pc_q + PC_INC;
                        if (stall) begin
                            skid_d  = imem_rdata;
                            state_d = ST_HOLD;
                        end else begin
                            load_mem = 1'b1;
                            state_d  = ST_ISSUE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        load_skid = 1'b1;
                        state_d   = ST_ISSUE;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid) state_d = ST_ISSUE;
                end
                default: state_d = ST_ISSUE;
            endcase
        end
        req_d = (state_d == ST_ISSUE);
    end

    // IF/ID next value: flush beats stall, stall freezes, otherwise load or bubble.
    always_comb begin
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        vld_d   = vld_q;
        bubble  = 1'b0;
        if (flush) begin
            instr_d = 32'h0;
            vld_d   = 1'b0;
        end else if (!stall) begin
            if (load_mem) begin
                instr_d = imem_rdata;
                pcp4_d  = pc_q + PC_INC;
                vld_d   = 1'b1;
            end else if (load_skid) begin
                // pc_q already advanced past the parked word when it completed
                instr_d = skid_q;
                pcp4_d  = pc_q;
                vld_d   = 1'b1;
            end else begin
                instr_d = 32'h0;
                vld_d   = 1'b0;
                bubble  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ISSUE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            skid_q  <= 32'h0;
            instr_q <= 32'h0;
            pcp4_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= pc_d;
            skid_q  <= skid_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            vld_q   <= vld_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign pc_plus4    = pcp4_q;
    assign instr_valid = vld_q;

`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            if (!flush && !stall && (load_mem || load_skid)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (flush || bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: directed cycle table, hand-written stall/redirect/wrap sequences,
// and randomized stall/redirect traffic checked against a program-order scoreboard.
module tb_mips_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        stall       = 1'b0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_plus4;
    logic        instr_valid;
`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] fetch_count, bubble_count;
`endif

    mips_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .opcode(opcode), .pc_plus4(pc_plus4), .instr_valid(instr_valid)
`ifdef MIPS_FETCH_PERF_EN
        , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h8C08_0004 ^ (a * 32'h0400_0401);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Instruction memory: answers each request after a latency, flags overlapping requests.
    int          lat      = 1;
    bit          lat_rand = 1'b0;
    bit          pend     = 1'b0;
    int          cd       = 0;
    logic [31:0] paddr    = 32'h0;
    logic [31:0] last_req_addr = 32'h0;

    always @(negedge clk) begin
        if (rst) begin
            pend        = 1'b0;
            imem_rvalid = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            if (pend) begin
                if (cd <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pend        = 1'b0;
                end else begin
                    cd--;
                end
            end
            if (imem_req) begin
                chk("single_outstanding", 32'(pend), 32'h0);
                pend  = 1'b1;
                cd    = lat_rand ? int'($urandom_range(1, 4)) : lat;
                paddr = imem_addr;
                last_req_addr = imem_addr;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall    = 1'b0;
        redirect = 1'b0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_rvalid();
        int n = 0;
        while (!imem_rvalid && n < 30) begin step(); n++; end
        chk("rvalid_timeout", 32'(imem_rvalid), 32'h1);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 30) begin step(); n++; end
        chk("req_timeout", 32'(imem_req), 32'h1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 30) begin step(); n++; end
        chk("valid_timeout", 32'(instr_valid), 32'h1);
    endtask

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ins;
        logic [31:0] p4;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tab[10];
        logic [31:0] e, a;
        logic [31:0] h_instr, h_p4;
        logic        h_vld;
        bit          got_req;

        // Cycle-by-cycle expectation after reset release, 1-cycle memory, no stall.
        tab[0] = '{1'b0, 32'h0,  1'b0, 32'h0,            32'h0};
        tab[1] = '{1'b1, 32'h0,  1'b0, 32'h0,            32'h0};
        tab[2] = '{1'b0, 32'h0,  1'b0, 32'h0,            32'h0};
        tab[3] = '{1'b1, 32'h4,  1'b1, mem_word(32'h0),  32'h4};
        tab[4] = '{1'b0, 32'h0,  1'b0, 32'h0,            32'h0};
        tab[5] = '{1'b1, 32'h8,  1'b1, mem_word(32'h4),  32'h8};
        tab[6] = '{1'b0, 32'h0,  1'b0, 32'h0,            32'h0};
        tab[7] = '{1'b1, 32'hC,  1'b1, mem_word(32'h8),  32'hC};
        tab[8] = '{1'b0, 32'h0,  1'b0, 32'h0,            32'h0};
        tab[9] = '{1'b1, 32'h10, 1'b1, mem_word(32'hC),  32'h10};

        lat = 1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            chk($sformatf("tab%0d_req", i), 32'(imem_req), 32'(tab[i].req));
            if (tab[i].req) chk($sformatf("tab%0d_addr", i), imem_addr, tab[i].addr);
            chk($sformatf("tab%0d_vld", i), 32'(instr_valid), 32'(tab[i].vld));
            chk($sformatf("tab%0d_instr", i), instr, tab[i].ins);
            e = tab[i].ins;
            chk($sformatf("tab%0d_opcode", i), 32'(opcode), 32'(e[31:26]));
            if (tab[i].vld) chk($sformatf("tab%0d_pcp4", i), pc_plus4, tab[i].p4);
        end
        chk("first_opcode_lw", 32'(mem_word(32'h0) >> 26), 32'h23);

        // Stall asserted in the cycle the word returns.
        wait_rvalid();
        a = last_req_addr;
        stall = 1'b1;
        h_instr = instr; h_vld = instr_valid; h_p4 = pc_plus4;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_instr", instr, h_instr);
            chk("stall_hold_vld", 32'(instr_valid), 32'(h_vld));
            chk("stall_hold_pcp4", pc_plus4, h_p4);
            chk("stall_no_req", 32'(imem_req), 32'h0);
        end
        stall = 1'b0;
        step();
        chk("unstall_vld", 32'(instr_valid), 32'h1);
        chk("unstall_instr", instr, mem_word(a));
        chk("unstall_pcp4", pc_plus4, a + 32'h4);
        chk("unstall_req_addr", imem_addr, a + 32'h4);

        // Redirect while waiting on a 3-cycle memory.
        lat = 3;
        do_reset();
        wait_req();
        step();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        chk("redir_flush_vld", 32'(instr_valid), 32'h0);
        chk("redir_flush_instr", instr, 32'h0);
        got_req = 1'b0;
        for (int i = 0; i < 30 && !instr_valid; i++) begin
            if (imem_req && !got_req) begin
                got_req = 1'b1;
                chk("redir_req_addr", imem_addr, 32'h100);
            end
            if (!got_req) chk("redir_no_stale", 32'(instr_valid), 32'h0);
            step();
        end
        chk("redir_saw_req", 32'(got_req), 32'h1);
        chk("redir_vld", 32'(instr_valid), 32'h1);
        chk("redir_instr", instr, mem_word(32'h100));
        chk("redir_pcp4", pc_plus4, 32'h104);

        // Redirect, rvalid and stall in the same cycle.
        lat = 1;
        wait_rvalid();
        redirect = 1'b1; redirect_pc = 32'h200; stall = 1'b1;
        step();
        redirect = 1'b0; stall = 1'b0;
        chk("combo_vld", 32'(instr_valid), 32'h0);
        chk("combo_instr", instr, 32'h0);
        chk("combo_req", 32'(imem_req), 32'h1);
        chk("combo_req_addr", imem_addr, 32'h200);
        wait_valid();
        chk("combo_pcp4", pc_plus4, 32'h204);

        // PC wrap at the top of the address space.
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        chk("wrap_req", 32'(imem_req), 32'h1);
        chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid();
        chk("wrap_instr", instr, mem_word(32'hFFFF_FFFC));
        chk("wrap_pcp4", pc_plus4, 32'h0);
        chk("wrap_next_addr", imem_addr, 32'h0);
`ifdef MIPS_FETCH_PERF_EN
        chk("wrap_fetch_count", fetch_count, 32'h1);
`endif

        // Random traffic against a program-order scoreboard.
        begin
            logic [31:0] exp_pc, tgt, p_instr, p_p4, f_cnt, b_cnt;
            logic        p_vld, p_stall, p_redir;
            int          n_deliv;
            lat_rand = 1'b1;
            do_reset();
            exp_pc = 32'h0; f_cnt = 32'h0; b_cnt = 32'h0; n_deliv = 0;
            p_instr = instr; p_vld = instr_valid; p_p4 = pc_plus4;
            for (int i = 0; i < 4000; i++) begin
                stall       = ($urandom_range(0, 3) == 0);
                redirect    = ($urandom_range(0, 24) == 0);
                redirect_pc = $urandom;
                p_stall = stall; p_redir = redirect;
                tgt = redirect_pc & ~32'h3;
                step();
                if (p_redir) begin
                    chk("rnd_flush_vld", 32'(instr_valid), 32'h0);
                    chk("rnd_flush_instr", instr, 32'h0);
                    exp_pc = tgt;
                    b_cnt++;
                end else if (p_stall) begin
                    chk("rnd_hold_instr", instr, p_instr);
                    chk("rnd_hold_vld", 32'(instr_valid), 32'(p_vld));
                    chk("rnd_hold_pcp4", pc_plus4, p_p4);
                end else if (instr_valid) begin
                    chk("rnd_instr", instr, mem_word(exp_pc));
                    chk("rnd_pcp4", pc_plus4, exp_pc + 32'h4);
                    exp_pc = exp_pc + 32'h4;
                    f_cnt++;
                    n_deliv++;
                end else begin
                    chk("rnd_bubble_instr", instr, 32'h0);
                    b_cnt++;
                end
                e = instr;
                chk("rnd_opcode", 32'(opcode), 32'(e[31:26]));
`ifdef MIPS_FETCH_PERF_EN
                chk("rnd_fetch_count", fetch_count, f_cnt);
                chk("rnd_bubble_count", bubble_count, b_cnt);
`endif
                p_instr = instr; p_vld = instr_valid; p_p4 = pc_plus4;
            end
            stall = 1'b0; redirect = 1'b0;
            chk("rnd_progress", 32'(n_deliv > 200), 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
